// File: rtl/addseq_pkg.sv
// Shared definitions for the sliced add/subtract sequencer.
// Optional status flags are enabled with the ADDSEQ_FLAGS_EN macro.
package addseq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_SLICE_W = 8;

  // Width of the slice index register; never narrower than one bit so a
  // single-slice build still has a legal register.
  function automatic int idx_w(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/addseq_ctrl_if.sv
// Request/response bundle for addseq_ctrl: operand handshake in, result
// handshake out. Flag signals exist only when ADDSEQ_FLAGS_EN is defined.
interface addseq_ctrl_if
  import addseq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              cout;
`ifdef ADDSEQ_FLAGS_EN
  logic              zero;
  logic              neg;
  logic              ovf;
`endif

  // Requester / consumer side
  modport master (
    output in_valid, op1, op2, sub, out_ready,
`ifdef ADDSEQ_FLAGS_EN
    input  zero, neg, ovf,
`endif
    input  in_ready, out_valid, result, cout
  );

  // Sequencer side
  modport slave (
    input  in_valid, op1, op2, sub, out_ready,
`ifdef ADDSEQ_FLAGS_EN
    output zero, neg, ovf,
`endif
    output in_ready, out_valid, result, cout
  );

endinterface

// File: rtl/addseq_slice.sv
// Combinational W-bit ripple-carry adder slice shared across all cycles of
// an operation. With ADDSEQ_FLAGS_EN it also exposes the carry into the MSB
// so the controller can derive signed overflow.
module addseq_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
`ifdef ADDSEQ_FLAGS_EN
  output logic         cmsb,
`endif
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi + 1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
  end

  assign cout = carry[W];
`ifdef ADDSEQ_FLAGS_EN
  assign cmsb = carry[W-1];
`endif

endmodule

// File: rtl/addseq_ctrl.sv
// Area-reduced DATA_W-bit add/subtract: one SLICE_W-bit slice processed per
// cycle, LSB first, with the inter-slice carry held in a register.
// Optional zero/neg/ovf outputs are enabled with the ADDSEQ_FLAGS_EN macro.
module addseq_ctrl
  import addseq_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SLICE_W = DEF_SLICE_W
) (
  input logic          clk,
  input logic          rst,
  addseq_ctrl_if.slave bus
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = idx_w(NSLICE);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NSLICE - 1);
  localparam logic [DATA_W-1:0] SLICE_MASK = DATA_W'({SLICE_W{1'b1}});

  if ((SLICE_W < 1) || (DATA_W < SLICE_W) || ((DATA_W % SLICE_W) != 0)) begin : g_bad_cfg
    $error("addseq_ctrl: DATA_W (%0d) must be a positive multiple of SLICE_W (%0d)",
           DATA_W, SLICE_W);
  end

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   op1_q, op1_d;
  logic [DATA_W-1:0]   op2_q, op2_d;   // already inverted for subtraction
  logic [DATA_W-1:0]   result_q, result_d;
  logic                cout_q, cout_d;
`ifdef ADDSEQ_FLAGS_EN
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
  logic                ovf_q, ovf_d;
  logic                sl_cmsb;
`endif

  int                  slice_base;
  logic [SLICE_W-1:0]  sl_a, sl_b, sl_sum;
  logic                sl_cout;
  logic [DATA_W-1:0]   merged;
  logic                in_ready_c, out_valid_c;

  // Select the current slice of both operands and splice its sum into the result
  always_comb begin
    slice_base = int'(idx_q) * SLICE_W;
    sl_a       = SLICE_W'(op1_q >> slice_base);
    sl_b       = SLICE_W'(op2_q >> slice_base);
    merged     = (result_q & ~(SLICE_MASK << slice_base))
               | (DATA_W'(sl_sum) << slice_base);
  end

  addseq_slice #(
    .W (SLICE_W)
  ) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
`ifdef ADDSEQ_FLAGS_EN
    .cmsb (sl_cmsb),
`endif
    .cout (sl_cout)
  );

  // Next-state and handshake outputs for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    result_d    = result_q;
    cout_d      = cout_q;
`ifdef ADDSEQ_FLAGS_EN
    zero_d      = zero_q;
    neg_d       = neg_q;
    ovf_d       = ovf_q;
`endif
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          op1_d   = bus.op1;
          op2_d   = bus.sub ? ~bus.op2 : bus.op2;
          carry_d = bus.sub;  // +1 completes the two's-complement negate
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        result_d = merged;
        carry_d  = sl_cout;
        idx_d    = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = sl_cout;
`ifdef ADDSEQ_FLAGS_EN
          zero_d  = (merged == '0);
          neg_d   = sl_sum[SLICE_W-1];
          ovf_d   = sl_cmsb ^ sl_cout;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand, carry and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ADDSEQ_FLAGS_EN
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ADDSEQ_FLAGS_EN
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
`ifdef ADDSEQ_FLAGS_EN
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_addseq_ctrl.sv
// Self-checking bench for addseq_ctrl (32-bit operands, 8-bit slices).
// Flag checks are compiled in when ADDSEQ_FLAGS_EN is defined.
module tb_addseq_ctrl;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = DATA_W / SLICE_W;
  localparam int BUDGET  = 50;

  typedef struct {
    logic [31:0] res;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sub;
    logic [31:0] res;
    logic        cout;
    int          hold;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     n_cmp = 0;
  int     n_fail = 0;
  exp_t   sb_q[$];
  vec_t   vecs[9];

  addseq_ctrl_if #(.DATA_W(DATA_W)) bus ();

  addseq_ctrl #(
    .DATA_W  (DATA_W),
    .SLICE_W (SLICE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain 33-bit addition with two's-complement operand
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] full;
    bb     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {32'd0, s};
    e.res  = full[31:0];
    e.cout = full[32];
    e.zero = (full[31:0] == 32'd0);
    e.neg  = full[31];
    e.ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
    return e;
  endfunction

  // One full transaction: request, latency check, optional backpressure, response
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eres, input logic ecout, input int hold);
    exp_t e;
    int   t;
    int   edges;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op1       = a;
    bus.op2       = b;
    bus.sub       = s;
    bus.out_ready = 1'b0;
    t = 0;
    while (!bus.in_ready && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    if (t >= BUDGET) begin
      check("accept_timeout", 64'd1, 64'd0);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e      = model(a, b, s);
    e.res  = eres;
    e.cout = ecout;
    sb_q.push_back(e);
    #1;
    // Scramble inputs after acceptance; the sequencer must ignore them
    bus.in_valid = 1'b0;
    bus.op1      = ~a;
    bus.op2      = $urandom;
    bus.sub      = ~s;
    @(negedge clk);
    check("busy_in_ready", {63'd0, bus.in_ready}, 64'd0);
    edges = 1;  // the accepting edge counts as the first
    while (!bus.out_valid && edges <= BUDGET) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      check("done_timeout", 64'd1, 64'd0);
      return;
    end
    check("latency", 64'(edges), 64'(NSLICE + 1));
    if (hold > 0) begin
      // A competing request during DONE must not be taken
      bus.in_valid = 1'b1;
      bus.op1      = 32'hDEAD_BEEF;
      bus.op2      = 32'h1234_5678;
      bus.sub      = 1'b0;
    end
    for (int i = 0; i < hold; i++) begin
      check("hold_out_valid", {63'd0, bus.out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
      check("hold_result", {32'd0, bus.result}, {32'd0, eres});
      check("hold_cout", {63'd0, bus.cout}, {63'd0, ecout});
      @(negedge clk);
    end
    e = sb_q.pop_front();
    check("result", {32'd0, bus.result}, {32'd0, e.res});
    check("cout", {63'd0, bus.cout}, {63'd0, e.cout});
`ifdef ADDSEQ_FLAGS_EN
    check("zero", {63'd0, bus.zero}, {63'd0, e.zero});
    check("neg", {63'd0, bus.neg}, {63'd0, e.neg});
    check("ovf", {63'd0, bus.ovf}, {63'd0, e.ovf});
`endif
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("post_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("post_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("post_result_kept", {32'd0, bus.result}, {32'd0, eres});
    $display("op1=%08h op2=%08h sub=%0d -> result=%08h cout=%0d", a, b, s, bus.result, bus.cout);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    exp_t        re;

    vecs = '{
      '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 0},
      '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 0},
      '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 0},
      '{32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 0},
      '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 6},
      '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1},
      '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 0},
      '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 0},
      '{32'h0000_0003, 32'h0000_0003, 1'b1, 32'h0000_0000, 1'b1, 0}
    };

    bus.in_valid  = 1'b0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_result", {32'd0, bus.result}, 64'd0);
    check("rst_cout", {63'd0, bus.cout}, 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op1, vecs[i].op2, vecs[i].sub, vecs[i].res, vecs[i].cout, vecs[i].hold);
    end

    // Randomised operations checked against the 33-bit reference
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      re = model(ra, rb, rs);
      run_op(ra, rb, rs, re.res, re.cout, int'($urandom_range(0, 2)));
    end

    // Reset during the second RUN cycle discards the operation
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op1      = 32'h0000_1234;
    bus.op2      = 32'h0000_1111;
    bus.sub      = 1'b0;
    check("midrst_idle", {63'd0, bus.in_ready}, 64'd1);
    @(posedge clk);          // accepting edge
    #1 bus.in_valid = 1'b0;
    @(posedge clk);          // first RUN cycle completes, second begins
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_result", {32'd0, bus.result}, 64'd0);
    repeat (6) @(negedge clk);
    check("midrst_no_late_valid", {63'd0, bus.out_valid}, 64'd0);
    run_op(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
